// File: rtl/regfile_wb_if.sv
// Execute-to-writeback bus for regfile_wb: ALU/LSU/MDU results, issue notifications,
// the busy scoreboard and the regfile write port.
interface regfile_wb_if;
  logic        alu_vld;
  logic [4:0]  alu_rd;
  logic [63:0] alu_d;
  logic        lsu_vld;
  logic        lsu_rdy;
  logic [4:0]  lsu_rd;
  logic [63:0] lsu_d;
  logic        mdu_vld;
  logic        mdu_rdy;
  logic [4:0]  mdu_rd;
  logic [63:0] mdu_d;
  logic        iss_vld;
  logic [4:0]  iss_rd;
  logic [31:0] busy;
  logic [63:0] d;
  logic [4:0]  rd;
  logic        wr;

  modport master (
    output alu_vld, alu_rd, alu_d,
    output lsu_vld, lsu_rd, lsu_d,
    output mdu_vld, mdu_rd, mdu_d,
    output iss_vld, iss_rd,
    input  lsu_rdy, mdu_rdy, busy, d, rd, wr
  );

  modport slave (
    input  alu_vld, alu_rd, alu_d,
    input  lsu_vld, lsu_rd, lsu_d,
    input  mdu_vld, mdu_rd, mdu_d,
    input  iss_vld, iss_rd,
    output lsu_rdy, mdu_rdy, busy, d, rd, wr
  );
endinterface

// File: rtl/regfile_wb.sv
// Writeback arbiter (ALU > LSU > MDU) onto the single regfile write port plus busy scoreboard.
// Define REGFILE_WB_STARVE_GUARD_EN to let a long-waiting MDU result outrank the LSU.
module regfile_wb #(
  parameter int STARVE_LIM = 8
) (
  input  logic         clk,
  input  logic         rst,
  regfile_wb_if.slave  bus
);

  logic        mdu_wins;
  logic        lsu_rdy;
  logic        mdu_rdy;

  logic        wr_q, wr_d;
  logic [4:0]  rd_q, rd_d;
  logic [63:0] d_q, d_d;
  logic [31:0] busy_q, busy_d;
  logic [31:0] clr_mask;
  logic [31:0] set_mask;

  // Grants: the ALU cannot stall, so it always pre-empts both other sources
  always_comb begin
    lsu_rdy = bus.lsu_vld & ~bus.alu_vld & ~mdu_wins;
    mdu_rdy = bus.mdu_vld & ~bus.alu_vld & (~bus.lsu_vld | mdu_wins);
  end

`ifdef REGFILE_WB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIM + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIM);

  logic [CW-1:0] starve_q, starve_d;

  // Starvation counter: counts blocked MDU cycles, saturating at the limit
  always_comb begin
    starve_d = starve_q;
    if (bus.mdu_vld & mdu_rdy) begin
      starve_d = {CW{1'b0}};
    end else if (bus.mdu_vld & ~mdu_rdy & (starve_q != LIM)) begin
      starve_d = starve_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      starve_d = starve_q;
    end
  end

  // Starvation counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= {CW{1'b0}};
    end else begin
      starve_q <= starve_d;
    end
  end

  assign mdu_wins = (starve_q == LIM);
`else
  assign mdu_wins = 1'b0;
`endif

  // Writeback mux: x0 results complete the handshake but never assert wr
  always_comb begin
    wr_d = 1'b0;
    rd_d = rd_q;
    d_d  = d_q;
    if (bus.alu_vld) begin
      wr_d = (bus.alu_rd != 5'd0);
      rd_d = bus.alu_rd;
      d_d  = bus.alu_d;
    end else if (lsu_rdy) begin
      wr_d = (bus.lsu_rd != 5'd0);
      rd_d = bus.lsu_rd;
      d_d  = bus.lsu_d;
    end else if (mdu_rdy) begin
      wr_d = (bus.mdu_rd != 5'd0);
      rd_d = bus.mdu_rd;
      d_d  = bus.mdu_d;
    end else begin
      wr_d = 1'b0;
      rd_d = rd_q;
      d_d  = d_q;
    end
  end

  // Scoreboard update: a same-cycle issue to the register being written keeps it busy
  always_comb begin
    clr_mask = wr_q ? (32'd1 << rd_q) : 32'd0;
    set_mask = (bus.iss_vld && (bus.iss_rd != 5'd0)) ? (32'd1 << bus.iss_rd) : 32'd0;
    busy_d   = ((busy_q & ~clr_mask) | set_mask) & ~32'd1;
  end

  // Write port and scoreboard registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q   <= 1'b0;
      rd_q   <= 5'd0;
      d_q    <= 64'd0;
      busy_q <= 32'd0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      d_q    <= d_d;
      busy_q <= busy_d;
    end
  end

  assign bus.lsu_rdy = lsu_rdy;
  assign bus.mdu_rdy = mdu_rdy;
  assign bus.wr      = wr_q;
  assign bus.rd      = rd_q;
  assign bus.d       = d_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_regfile_wb.sv
// Self-checking bench for regfile_wb: directed scenarios plus randomized traffic
// compared against a cycle-level reference model of the arbitration and scoreboard rules.
module tb_regfile_wb;
  localparam int LIM = 8;

  logic clk = 1'b0;
  logic rst;
  regfile_wb_if bus();

  regfile_wb #(.STARVE_LIM(LIM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  bit          m_wr;
  logic [4:0]  m_rd;
  logic [63:0] m_d;
  bit          m_busy [32];
  int          m_wait;
  bit          lsu_took;
  bit          mdu_took;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] busy_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic model_reset();
    m_wr = 1'b0; m_rd = 5'd0; m_d = 64'd0; m_wait = 0;
    lsu_took = 1'b0; mdu_took = 1'b0;
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.alu_vld = 1'b0; bus.alu_rd = 5'd0; bus.alu_d = 64'd0;
    bus.lsu_vld = 1'b0; bus.lsu_rd = 5'd0; bus.lsu_d = 64'd0;
    bus.mdu_vld = 1'b0; bus.mdu_rd = 5'd0; bus.mdu_d = 64'd0;
    bus.iss_vld = 1'b0; bus.iss_rd = 5'd0;
  endtask

  // One clock: check grants and registered outputs at negedge, advance model, return at posedge+1
  task automatic cyc();
    bit mw, g_l, g_m;
    @(negedge clk);
`ifdef REGFILE_WB_STARVE_GUARD_EN
    mw = (m_wait >= LIM);
`else
    mw = 1'b0;
`endif
    g_l = bus.lsu_vld && !bus.alu_vld && !mw;
    g_m = bus.mdu_vld && !bus.alu_vld && (!bus.lsu_vld || mw);
    check("lsu_rdy", bus.lsu_rdy, g_l);
    check("mdu_rdy", bus.mdu_rdy, g_m);
    check("wr", bus.wr, m_wr);
    if (m_wr) begin
      check("rd", bus.rd, m_rd);
      check("d", bus.d, m_d);
    end
    check("busy", bus.busy, busy_vec());
    if (m_wr) m_busy[m_rd] = 1'b0;
    if (bus.iss_vld && bus.iss_rd != 5'd0) m_busy[bus.iss_rd] = 1'b1;
    if (bus.alu_vld) begin
      m_wr = (bus.alu_rd != 5'd0); m_rd = bus.alu_rd; m_d = bus.alu_d;
    end else if (g_l) begin
      m_wr = (bus.lsu_rd != 5'd0); m_rd = bus.lsu_rd; m_d = bus.lsu_d;
    end else if (g_m) begin
      m_wr = (bus.mdu_rd != 5'd0); m_rd = bus.mdu_rd; m_d = bus.mdu_d;
    end else begin
      m_wr = 1'b0;
    end
    if (g_m) m_wait = 0;
    else if (bus.mdu_vld && m_wait < LIM) m_wait++;
    lsu_took = g_l;
    mdu_took = g_m;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit mdone;
    bit exp_rdy;
    rst = 1'b1;
    idle_inputs();
    model_reset();
    #12;
    check("reset_wr", bus.wr, 1'b0);
    check("reset_busy", bus.busy, 32'd0);
    check("reset_d", bus.d, 64'd0);
    check("reset_rd", bus.rd, 5'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single ALU result
    bus.alu_vld = 1'b1; bus.alu_rd = 5'd5; bus.alu_d = 64'h1234;
    cyc();
    bus.alu_vld = 1'b0;
    check("alu_wr", bus.wr, 1'b1);
    check("alu_rd", bus.rd, 5'd5);
    check("alu_d", bus.d, 64'h1234);
    cyc();
    check("alu_wr_drop", bus.wr, 1'b0);

    // Three-way contention
    bus.alu_vld = 1'b1; bus.alu_rd = 5'd2; bus.alu_d = 64'haa;
    bus.lsu_vld = 1'b1; bus.lsu_rd = 5'd3; bus.lsu_d = 64'hbb;
    bus.mdu_vld = 1'b1; bus.mdu_rd = 5'd4; bus.mdu_d = 64'hcc;
    #2;
    check("3way_lsu_rdy", bus.lsu_rdy, 1'b0);
    cyc();
    bus.alu_vld = 1'b0;
    check("3way_alu_rd", bus.rd, 5'd2);
    cyc();
    bus.lsu_vld = 1'b0;
    check("3way_lsu_rd", bus.rd, 5'd3);
    check("3way_lsu_d", bus.d, 64'hbb);
    cyc();
    bus.mdu_vld = 1'b0;
    check("3way_mdu_rd", bus.rd, 5'd4);
    check("3way_mdu_d", bus.d, 64'hcc);
    cyc();

    // Scoreboard: issue, LSU return, clear two cycles after acceptance
    bus.iss_vld = 1'b1; bus.iss_rd = 5'd7;
    cyc();
    bus.iss_vld = 1'b0;
    check("sb_set", bus.busy[7], 1'b1);
    cyc();
    cyc();
    bus.lsu_vld = 1'b1; bus.lsu_rd = 5'd7; bus.lsu_d = 64'h77;
    cyc();
    bus.lsu_vld = 1'b0;
    check("sb_wr_cycle", bus.busy[7], 1'b1);
    cyc();
    check("sb_clear", bus.busy[7], 1'b0);
    // Re-issue in the same cycle as wr keeps the bit set
    bus.iss_vld = 1'b1; bus.iss_rd = 5'd7;
    cyc();
    bus.iss_vld = 1'b0;
    bus.lsu_vld = 1'b1; bus.lsu_rd = 5'd7; bus.lsu_d = 64'h78;
    cyc();
    bus.lsu_vld = 1'b0;
    bus.iss_vld = 1'b1; bus.iss_rd = 5'd7;
    check("sb_wr2", bus.wr, 1'b1);
    cyc();
    bus.iss_vld = 1'b0;
    check("sb_set_wins", bus.busy[7], 1'b1);
    bus.alu_vld = 1'b1; bus.alu_rd = 5'd7; bus.alu_d = 64'h79;
    cyc();
    bus.alu_vld = 1'b0;
    cyc();
    cyc();

    // x0 result from the MDU
    bus.mdu_vld = 1'b1; bus.mdu_rd = 5'd0; bus.mdu_d = 64'hdead;
    #2;
    check("x0_mdu_rdy", bus.mdu_rdy, 1'b1);
    cyc();
    bus.mdu_vld = 1'b0;
    check("x0_wr", bus.wr, 1'b0);
    check("x0_busy0", bus.busy[0], 1'b0);
    cyc();

    // Starvation window: LSU and MDU held valid continuously
    mdone = 1'b0;
    bus.lsu_vld = 1'b1; bus.lsu_rd = 5'd10; bus.lsu_d = 64'h1010;
    bus.mdu_vld = 1'b1; bus.mdu_rd = 5'd9;  bus.mdu_d = 64'h9999;
    for (int i = 0; i < 20; i++) begin
      #2;
`ifdef REGFILE_WB_STARVE_GUARD_EN
      exp_rdy = (i == LIM);
`else
      exp_rdy = 1'b0;
`endif
      if (!mdone) check("starve_mdu_rdy", bus.mdu_rdy, exp_rdy);
      cyc();
      if (mdu_took) begin
        mdone = 1'b1;
        bus.mdu_vld = 1'b0;
      end
    end
    bus.lsu_vld = 1'b0;
    cyc();
    if (mdu_took) bus.mdu_vld = 1'b0;
    cyc();
    cyc();

    // Randomized traffic; LSU/MDU hold their request until accepted
    for (int n = 0; n < 400; n++) begin
      if (!(bus.lsu_vld && !lsu_took)) begin
        bus.lsu_vld = ($urandom_range(0, 1) == 0);
        bus.lsu_rd  = 5'($urandom);
        bus.lsu_d   = {$urandom(), $urandom()};
      end
      if (!(bus.mdu_vld && !mdu_took)) begin
        bus.mdu_vld = ($urandom_range(0, 2) == 0);
        bus.mdu_rd  = 5'($urandom);
        bus.mdu_d   = {$urandom(), $urandom()};
      end
      bus.alu_vld = ($urandom_range(0, 3) == 0);
      bus.alu_rd  = 5'($urandom);
      bus.alu_d   = {$urandom(), $urandom()};
      bus.iss_vld = ($urandom_range(0, 2) == 0);
      bus.iss_rd  = 5'($urandom);
      cyc();
    end
    idle_inputs();
    cyc();

    // Asynchronous reset mid-cycle with a writeback and busy bits pending
    bus.alu_vld = 1'b1; bus.alu_rd = 5'd6; bus.alu_d = 64'h6666;
    bus.iss_vld = 1'b1; bus.iss_rd = 5'd8;
    cyc();
    idle_inputs();
    #2;
    rst = 1'b1;
    #1;
    check("midrst_wr", bus.wr, 1'b0);
    check("midrst_busy", bus.busy, 32'd0);
    check("midrst_d", bus.d, 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cyc();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb.md
# regfile_wb

Writeback stage for the integer register file: collects results from the ALU, the load/store unit (LSU) and the multiply/divide unit (MDU), arbitrates them onto the regfile's single write port (`d`/`rd`/`wr`), and keeps a busy scoreboard of destination registers with pending writes. It sits between the execute units and `regfile`. The decode/issue logic uses it to stall on read-after-write hazards.

## Interface
Parameters:
- `STARVE_LIM`, default 8: cycles an MDU result may wait before it outranks the LSU (used only with the starvation guard).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `alu_vld`  in  1  ALU result valid; the ALU cannot be stalled.
- `alu_rd`  in  5  ALU destination register.
- `alu_d`  in  64  ALU result.
- `lsu_vld`  in  1  LSU result valid.
- `lsu_rdy`  out  1  LSU result accepted this cycle.
- `lsu_rd`  in  5  LSU destination register.
- `lsu_d`  in  64  LSU result.
- `mdu_vld`  in  1  MDU result valid.
- `mdu_rdy`  out  1  MDU result accepted this cycle.
- `mdu_rd`  in  5  MDU destination register.
- `mdu_d`  in  64  MDU result.
- `iss_vld`  in  1  instruction issued with a destination register.
- `iss_rd`  in  5  destination register of the issued instruction.
- `busy`  out  32  scoreboard; bit i set means xi has a pending write. Bit 0 is always 0.
- `d`  out  64  regfile write data.
- `rd`  out  5  regfile write address.
- `wr`  out  1  regfile write enable.

## Operation
- Fixed priority: ALU > LSU > MDU. The starvation guard can swap LSU and MDU (see Configuration).
- `lsu_rdy`/`mdu_rdy` are combinational grants:
  - `lsu_rdy = lsu_vld & !alu_vld & !mdu_wins`
  - `mdu_rdy = mdu_vld & !alu_vld & (!lsu_vld | mdu_wins)`
- A transfer occurs when vld and rdy are both high. A source must hold vld, rd and d stable until its transfer occurs.
- Accepted result is registered into `d`/`rd`, and `wr` is set for one cycle.
- `wr` is forced to 0 when the accepted rd is 0. The handshake still completes.
- Scoreboard:
  - `iss_vld` with `iss_rd != 0` sets `busy[iss_rd]`.
  - `wr` with `rd` clears `busy[rd]`.
  - If set and clear hit the same register in the same cycle, set wins (new producer outstanding).
- No accepted result is ever dropped. An ALU result is never delayed.

## Timing
- Reset values: `d` = 0, `rd` = 0, `wr` = 0, `busy` = 0, starvation counter = 0.
- Reset asserted mid-operation clears all of the above immediately. A pending writeback is lost; an in-flight handshake does not complete.
- Latency: result accepted in cycle N gives `wr` high in cycle N+1. The regfile commits at the end of N+1. `busy` bit clears from N+2.
- Issue in cycle N gives the busy bit set from cycle N+1.
- Back-to-back acceptance every cycle is supported: throughput is 1 write per cycle.
- Both LSU and MDU valid with no ALU: exactly one is granted. The other waits with vld held.

## Configuration
- `REGFILE_WB_STARVE_GUARD_EN` defined:
  - An internal counter increments each cycle `mdu_vld & !mdu_rdy`.
  - It resets to 0 on an MDU transfer.
  - It saturates at `STARVE_LIM`.
  - At `STARVE_LIM`, `mdu_wins` = 1: the MDU outranks the LSU, but never the ALU.
- Not defined:
  - `mdu_wins` is tied 0 and the counter is not built.
  - Under continuous LSU traffic the MDU may starve indefinitely.

## Test plan
- Reset check: assert `rst` asynchronously mid-cycle. Require `wr` = 0, `busy` = 0 and `d` = 0 immediately, before the next clock edge.
- Single ALU result: `alu_vld`=1, rd=5, d=0x1234 in cycle N. Require `wr`=1, `rd`=5, `d`=0x1234 in N+1 and `wr`=0 in N+2.
- Three-way contention: ALU, LSU (rd=3) and MDU (rd=4) all valid in cycle N. Require ALU written in N+1, LSU in N+2, MDU in N+3, and `lsu_rdy`=0 during N.
- Scoreboard: issue rd=7 in cycle N, then return an LSU result to rd=7 later.
  - Require `busy[7]`=1 from N+1 until two cycles after acceptance.
  - Issue rd=7 again in the same cycle as its `wr`: require `busy[7]` to stay 1.
- x0 handling: MDU result rd=0 with `mdu_vld`=1. Require `mdu_rdy`=1, `wr`=0 in the next cycle, and `busy[0]`=0 throughout.
- Starvation guard, `REGFILE_WB_STARVE_GUARD_EN` defined, `STARVE_LIM`=8: hold LSU and MDU valid continuously.
  - Require `mdu_rdy`=1 in the 9th cycle after MDU valid.
  - With the macro undefined, require `mdu_rdy`=0 for the full 20-cycle window.
